relu_maxpool2x2: RTL and testbench

Streaming ReLU and 2x2/stride-2 max-pooling stage that sits directly downstream of the channel-sum adder in the CNN datapath. It consumes one signed convolution sum per cycle in raster order for a W x H feature map. It clamps negative sums to zero and emits one pooled value per 2x2 window. A half-width line buffer holds the pair-maxima of each even row until the matching odd row arrives.

---
 rtl/relu_maxpool2x2.sv | 81 ++++++++
 tb/tb_relu_maxpool2x2.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/relu_maxpool2x2.sv
// Streaming ReLU followed by 2x2 / stride-2 max pooling over a W x H raster feature map.
// Even rows park their horizontal pair maxima in a half-width line buffer until the odd row arrives.
module relu_maxpool2x2 #(
  parameter int DW = 10,
  parameter int W  = 24,
  parameter int H  = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_data,
  output logic                 frame_done
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam int RW = (H > 2) ? $clog2(H) : 1;
  localparam int LW = (W > 2) ? $clog2(W / 2) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [DW-1:0] h;
  logic [DW-1:0] linebuf [W/2];

  logic [DW-1:0] r;
  logic [DW-1:0] m;
  logic [DW-1:0] lb_rd;
  logic [DW-1:0] p;
  logic [LW-1:0] lb_idx;
  logic          lb_we;

  // After clamping, both operands are non-negative, so plain unsigned compares give the signed maximum.
  assign r      = in_data[DW-1] ? '0 : in_data;
  assign m      = (h > r) ? h : r;
  assign lb_idx = LW'(col >> 1);
  assign lb_rd  = linebuf[lb_idx];
  assign p      = (lb_rd > m) ? lb_rd : m;
  assign lb_we  = rst_n && in_valid && col[0] && !row[0];

  // NOTE: the line buffer has no reset; every entry is written on an even row before the
  // odd row reads it, so clearing it would only cost a reset fan-out across the array.
  always_ff @(posedge clk) begin
    if (lb_we) linebuf[lb_idx] <= m;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      h          <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        if (!col[0]) begin
          h <= r;
        end else if (row[0]) begin
          out_valid  <= 1'b1;
          out_data   <= p;
          frame_done <= (row == ROW_LAST) && (col == COL_LAST);
        end

        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Bench for relu_maxpool2x2: a pixel-array reference model checked every cycle, plus
// literal expectations for the directed frames.
module tb_relu_maxpool2x2;

  localparam int DW = 10;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int NP = W * H;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] in_data = '0;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic                 frame_done;

  relu_maxpool2x2 #(.DW(DW), .W(W), .H(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: remembers the clamped frame as a flat pixel array and, whenever the
  // bottom-right pixel of a 2x2 window is accepted, takes the max of its four pixels.
  int img [NP];
  int pix = 0;
  int exp_valid = 0;
  int exp_data  = 0;
  int exp_done  = 0;

  function automatic int relu(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  always @(posedge clk) begin
    int v, rr, cc, mx;
    if (!rst_n) begin
      pix       <= 0;
      exp_valid <= 0;
      exp_data  <= 0;
      exp_done  <= 0;
    end else if (in_valid) begin
      v  = relu(int'(in_data));
      rr = pix / W;
      cc = pix % W;
      img[pix] <= v;
      if ((rr % 2 == 1) && (cc % 2 == 1)) begin
        mx = v;
        if (img[pix-1]   > mx) mx = img[pix-1];
        if (img[pix-W]   > mx) mx = img[pix-W];
        if (img[pix-W-1] > mx) mx = img[pix-W-1];
        exp_valid <= 1;
        exp_data  <= mx;
        exp_done  <= (pix == NP - 1) ? 1 : 0;
      end else begin
        exp_valid <= 0;
        exp_done  <= 0;
      end
      pix <= (pix + 1) % NP;
    end else begin
      exp_valid <= 0;
      exp_done  <= 0;
    end
  end

  // Per-cycle comparison on the falling edge, plus capture of emitted results.
  int got[$];
  int done_cnt = 0;
  int done_val = -1;

  always @(negedge clk) begin
    check("out_valid", int'(out_valid), exp_valid);
    check("frame_done", int'(frame_done), exp_done);
    check("out_data", int'(out_data), exp_data);
    if (out_valid) got.push_back(int'(out_data));
    if (frame_done) begin
      done_cnt++;
      done_val = int'(out_data);
    end
  end

  task automatic send(input int v);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = DW'(v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
    end
  endtask

  task automatic expect_seq(input string name, input int e[$]);
    check({name, " count"}, got.size(), e.size());
    for (int i = 0; i < e.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", name, i), got[i], e[i]);
  endtask

  int exp_q[$];

  initial begin
    // 1. reset hold with a live input that must be ignored
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = DW'(100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset out_valid", int'(out_valid), 0);
      check("reset out_data", int'(out_data), 0);
      check("reset frame_done", int'(frame_done), 0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // 2. ramp frame
    got.delete();
    done_cnt = 0;
    for (int i = 0; i < NP; i++) send(i);
    idle(3);
    exp_q = '{5, 7, 13, 15};
    expect_seq("ramp", exp_q);
    check("ramp done count", done_cnt, 1);
    check("ramp done value", done_val, 15);

    // 3. negative clamp, including the most negative code and the largest positive
    got.delete();
    for (int i = 0; i < NP; i++) send(i == 0 ? -512 : (i == 10 ? 511 : -1));
    idle(3);
    exp_q = '{0, 0, 0, 511};
    expect_seq("clamp", exp_q);

    // 4. ramp with two idle cycles after every third sample
    got.delete();
    for (int i = 0; i < NP; i++) begin
      send(i);
      if (i % 3 == 2) idle(2);
    end
    idle(3);
    exp_q = '{5, 7, 13, 15};
    expect_seq("bubbles", exp_q);

    // 5. abort a partial frame with a one-cycle reset, then a full ramp
    for (int i = 0; i < 6; i++) send(i);
    idle(2);
    got.delete();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = DW'(300);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < NP; i++) send(i);
    idle(3);
    exp_q = '{5, 7, 13, 15};
    expect_seq("mid reset", exp_q);
    check("mid reset done count", done_cnt, 1);

    // 6. back-to-back frames with no gap
    got.delete();
    done_cnt = 0;
    for (int i = 0; i < NP; i++) send(i);
    for (int i = 0; i < NP; i++) send(15 - i);
    idle(3);
    exp_q = '{5, 7, 13, 15, 15, 13, 7, 5};
    expect_seq("b2b", exp_q);
    check("b2b done count", done_cnt, 2);

    // Random frames with random bubbles, checked cycle by cycle against the model.
    got.delete();
    done_cnt = 0;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NP; i++) begin
        send(int'($signed(DW'($urandom_range(0, (1 << DW) - 1)))));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    idle(3);
    check("random result count", got.size(), 4 * (W / 2) * (H / 2));
    check("random done count", done_cnt, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
